// File: rtl/vram_pkg.sv
// vram_pkg: shared widths and arbiter state encoding for the VRAM arbiter slice.
package vram_pkg;

  localparam int unsigned VRAM_AW = 15;
  localparam int unsigned VRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_vid_pipe.sv
// vram_vid_pipe: two-stage delay line for scanout reads. A read granted in
// cycle t lands in vid_dout at the end of t+1 and is flagged by vid_valid in
// t+2; a read dropped in cycle t is flagged by vid_miss in t+2 instead.
module vram_vid_pipe
  import vram_pkg::*;
#(
  parameter int unsigned DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          grant_vid,
  input  logic          drop_vid,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] vid_dout,
  output logic          vid_valid,
  output logic          vid_miss
);

  logic rd_pend;
  logic miss_pend;

  // Track in-flight reads/drops and capture RAM data one cycle after the grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend   <= 1'b0;
      miss_pend <= 1'b0;
      vid_valid <= 1'b0;
      vid_miss  <= 1'b0;
      vid_dout  <= '0;
    end else begin
      rd_pend   <= grant_vid;
      miss_pend <= drop_vid;
      vid_valid <= rd_pend;
      vid_miss  <= miss_pend;
      if (rd_pend) begin
        vid_dout <= ram_dout;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port, 1-cycle-latency VRAM between scanout
// fetch (fixed-slot reads, priority) and the 68k bus bridge (req/ack access).
// Optional starvation guard enabled by defining VRAM_STARVE_GUARD_EN: after
// MAX_WAIT refused cycles the CPU wins and the colliding video read is dropped.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned AW       = VRAM_AW,
  parameter int unsigned DW       = VRAM_DW,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned STALL_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vid_req,
  input  logic [AW-1:0]      vid_addr,
  output logic [DW-1:0]      vid_dout,
  output logic               vid_valid,
  output logic               vid_miss,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_din,
  output logic [DW-1:0]      cpu_dout,
  output logic               cpu_ack,
  output logic [STALL_W-1:0] cpu_stall,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_we,
  output logic [DW-1:0]      ram_din,
  input  logic [DW-1:0]      ram_dout
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic grant_cpu_c;
  logic grant_vid_c;
  logic guard_fire_c;
  logic drop_vid_c;
  logic cpu_refused_c;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Count refused IDLE cycles up to MAX_WAIT; a CPU grant restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (grant_cpu_c) begin
      wait_cnt <= '0;
    end else if (cpu_refused_c && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign guard_fire_c = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign drop_vid_c   = vid_req & grant_cpu_c;
`else
  localparam int unsigned unused_max_wait = MAX_WAIT;

  assign guard_fire_c = 1'b0;
  assign drop_vid_c   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant decision, next state and RAM port mux
  always_comb begin
    state_nxt     = state;
    grant_cpu_c   = 1'b0;
    grant_vid_c   = 1'b0;
    cpu_refused_c = 1'b0;
    ram_addr      = vid_addr;
    ram_we        = 1'b0;
    ram_din       = '0;

    if ((state == IDLE) && cpu_req && (!vid_req || guard_fire_c)) begin
      grant_cpu_c = 1'b1;
    end
    cpu_refused_c = (state == IDLE) && cpu_req && !grant_cpu_c;
    grant_vid_c   = vid_req && !grant_cpu_c;

    case (state)
      IDLE: begin
        if (grant_cpu_c) begin
          state_nxt = cpu_we ? ACK : RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (grant_cpu_c) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      ram_din  = cpu_din;
    end
  end

  assign cpu_ack = (state == ACK);

  // CPU read data arrives the cycle after its grant, i.e. while in RD_WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout <= '0;
    end else if (state == RD_WAIT) begin
      cpu_dout <= ram_dout;
    end
  end

  // Saturating count of cycles the CPU request was refused
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_stall <= '0;
    end else if (cpu_refused_c && (cpu_stall != {STALL_W{1'b1}})) begin
      cpu_stall <= cpu_stall + STALL_W'(1);
    end
  end

  vram_vid_pipe #(
    .DW (DW)
  ) u_vid_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .grant_vid (grant_vid_c),
    .drop_vid  (drop_vid_c),
    .ram_dout  (ram_dout),
    .vid_dout  (vid_dout),
    .vid_valid (vid_valid),
    .vid_miss  (vid_miss)
  );

endmodule
